fifo_flags_ip: RTL and testbench
================================

// Module: fifo_flags_ip
// PURPOSE
//   Parametrised synchronous FIFO, successor to the basic fifo_ip. Adds an occupancy count,
//   almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable
//   first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in
//   the same clock domain and replaces fifo_ip where back-pressure needs an early warning.
// PARAMETERS
//   WordLength      8  data width in bits
//   AddrBits        3  pointer width; DEPTH = 2**AddrBits entries
//   AlmostFullThr   6  almost_full_o asserted when count >= AlmostFullThr (1..DEPTH)
//   AlmostEmptyThr  2  almost_empty_o asserted when count <= AlmostEmptyThr (0..DEPTH-1)
//   Fwft            0  0 = registered read; 1 = first-word-fall-through
// PORTS
//   clk_i           in   1             clock; all logic on the rising edge
//   rst_i           in   1             synchronous reset, active-high
//   wr_i            in   1             write request
//   w_data_i        in   WordLength    write data
//   rd_i            in   1             read request
//   r_data_o        out  WordLength    read data
//   empty_o         out  1             count == 0
//   full_o          out  1             count == DEPTH
//   almost_empty_o  out  1             count <= AlmostEmptyThr
//   almost_full_o   out  1             count >= AlmostFullThr
//   count_o         out  AddrBits+1    current occupancy, 0..DEPTH
//   overflow_o      out  1             1-cycle pulse: write rejected
//   underflow_o     out  1             1-cycle pulse: read rejected
// BEHAVIOUR
//   - Reset (rst_i=1 at an edge): wr_ptr=rd_ptr=0, count_o=0, empty_o=1, almost_empty_o=1,
//     full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, r_data_o=0.
//     Reset mid-operation discards all content. Memory contents are not cleared.
//   - rd_acc = rd_i & ~empty_o.
//     wr_acc = wr_i & (~full_o | rd_acc): a write while full is accepted only when a read is
//     accepted in the same cycle.
//   - Write while empty plus read in the same cycle: the write is accepted and the read is
//     rejected (underflow pulse). The word is readable from the next cycle.
//   - On wr_acc: mem[wr_ptr] <= w_data_i and wr_ptr++. On rd_acc: rd_ptr++.
//     Pointers are AddrBits wide and wrap DEPTH-1 -> 0 with no special case.
//   - count_o next = count_o + wr_acc - rd_acc (registered). All four flags are registered
//     and consistent with count_o in the same cycle.
//   - overflow_o <= wr_i & ~wr_acc. underflow_o <= rd_i & ~rd_acc. Both are 1-cycle pulses
//     registered one cycle after the offending request. Pointers and count are unchanged
//     by a rejected request.
//   - Fwft=0: on rd_acc, r_data_o <= mem[rd_ptr], valid the cycle after rd_i. Otherwise
//     r_data_o holds its last value.
//   - Fwft=1: r_data_o = empty_o ? 0 : mem[rd_ptr] (combinational from registered state).
//     The head word is visible with zero latency; rd_i acknowledges and pops it.
//   - Write latency to empty_o deassert: 1 cycle. In FWFT mode data is valid in that same
//     cycle.
//   - Threshold parameters outside their stated ranges are illegal: elaboration $error.
// TESTING  (WordLength=8, AddrBits=3, AlmostFullThr=6, AlmostEmptyThr=2)
//   1 Reset, then idle -> count_o=0, empty_o=1, almost_empty_o=1, full_o=0, r_data_o=0.
//   2 Write 8'h01..8'h08, one per cycle -> almost_empty_o drops after the 3rd write,
//     almost_full_o rises after the 6th, full_o=1 and count_o=8 after the 8th. A 9th write
//     (8'hFF) -> overflow_o pulses once; contents unchanged.
//   3 Fwft=0, read 8 words -> r_data_o = 01..08, each one cycle after rd_i. A 9th read ->
//     underflow_o pulses; r_data_o holds 8'h08; empty_o=1.
//   4 Full FIFO, wr_i=rd_i=1 with 8'hAA -> write accepted, count_o stays 8, no overflow.
//     Empty FIFO, wr_i=rd_i=1 -> count_o=1, underflow_o pulses.
//   5 Fwft=1, write 8'h5A into an empty FIFO -> next cycle empty_o=0 and r_data_o=8'h5A
//     with no rd_i. Pop it -> r_data_o=0 and empty_o=1.
//   6 Wrap: 20 interleaved write/read pairs (incrementing data) -> in-order data across
//     pointer wrap. Assert rst_i with count_o=5 -> next cycle count_o=0, empty_o=1.

Source files
------------

// File: rtl/fifo_flags_ip.sv
// rtl/fifo_flags_ip.sv - synchronous FIFO with count, threshold flags, error pulses, FWFT option
// Flags are computed from the next count, so they always agree with count_o.
module fifo_flags_ip #(
  parameter int WordLength     = 8,
  parameter int AddrBits       = 3,
  parameter int AlmostFullThr  = 6,
  parameter int AlmostEmptyThr = 2,
  parameter int Fwft           = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [WordLength-1:0] w_data_i,
  input  logic                  rd_i,
  output logic [WordLength-1:0] r_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [AddrBits:0]     count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << AddrBits;
  localparam logic [AddrBits:0] C_DEPTH = (AddrBits+1)'(DEPTH);
  localparam logic [AddrBits:0] C_AF    = (AddrBits+1)'(AlmostFullThr);
  localparam logic [AddrBits:0] C_AE    = (AddrBits+1)'(AlmostEmptyThr);

  if (AlmostFullThr < 1 || AlmostFullThr > DEPTH) begin : g_bad_af
    $error("fifo_flags_ip: AlmostFullThr out of range 1..DEPTH");
  end
  if (AlmostEmptyThr < 0 || AlmostEmptyThr > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flags_ip: AlmostEmptyThr out of range 0..DEPTH-1");
  end

  logic [WordLength-1:0] r_mem [DEPTH];
  logic [AddrBits-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AddrBits:0]     r_count;
  logic                  r_empty, r_full, r_aempty, r_afull, r_ovf, r_unf;

  logic                  w_rd_acc, w_wr_acc;
  logic [AddrBits:0]     w_count_nxt;

  // A full FIFO can still take a write when the same cycle frees a slot.
  assign w_rd_acc    = rd_i & ~r_empty;
  assign w_wr_acc    = wr_i & (~r_full | w_rd_acc);
  assign w_count_nxt = r_count + (AddrBits+1)'(w_wr_acc) - (AddrBits+1)'(w_rd_acc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == C_DEPTH);
      r_aempty <= (w_count_nxt <= C_AE);
      r_afull  <= (w_count_nxt >= C_AF);
      r_ovf    <= wr_i & ~w_wr_acc;
      r_unf    <= rd_i & ~w_rd_acc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr_acc) r_mem[r_wr_ptr] <= w_data_i;
  end

  if (Fwft != 0) begin : g_fwft
    assign r_data_o = r_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [WordLength-1:0] r_rdata;
    always_ff @(posedge clk_i) begin
      if (rst_i)         r_rdata <= '0;
      else if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr];
    end
    assign r_data_o = r_rdata;
  end

  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_empty_o = r_aempty;
  assign almost_full_o  = r_afull;
  assign count_o        = r_count;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule

// File: tb/tb_fifo_flags_ip.sv
// tb/tb_fifo_flags_ip.sv - scoreboard bench driving a registered-read and an FWFT instance in lockstep
module tb_fifo_flags_ip;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr  = 1'b0;
  logic       rd  = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic [7:0] rdata_r, rdata_f;
  logic       empty_r, full_r, aempty_r, afull_r, ovf_r, unf_r;
  logic       empty_f, full_f, aempty_f, afull_f, ovf_f, unf_f;
  logic [3:0] count_r, count_f;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];
  logic [7:0] last_rd;

  always #5 clk = ~clk;

  fifo_flags_ip #(.WordLength(8), .AddrBits(3), .AlmostFullThr(6), .AlmostEmptyThr(2), .Fwft(0)) u_dut_reg (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .w_data_i(wdata), .rd_i(rd), .r_data_o(rdata_r),
    .empty_o(empty_r), .full_o(full_r), .almost_empty_o(aempty_r), .almost_full_o(afull_r),
    .count_o(count_r), .overflow_o(ovf_r), .underflow_o(unf_r));

  fifo_flags_ip #(.WordLength(8), .AddrBits(3), .AlmostFullThr(6), .AlmostEmptyThr(2), .Fwft(1)) u_dut_fwft (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .w_data_i(wdata), .rd_i(rd), .r_data_o(rdata_f),
    .empty_o(empty_f), .full_o(full_f), .almost_empty_o(aempty_f), .almost_full_o(afull_f),
    .count_o(count_f), .overflow_o(ovf_f), .underflow_o(unf_f));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input logic exp_ovf, input logic exp_unf);
    int n;
    n = model_q.size();
    chk("count_r",  32'(count_r),  32'(n));
    chk("count_f",  32'(count_f),  32'(n));
    chk("empty_r",  32'(empty_r),  32'(n == 0));
    chk("empty_f",  32'(empty_f),  32'(n == 0));
    chk("full_r",   32'(full_r),   32'(n == 8));
    chk("full_f",   32'(full_f),   32'(n == 8));
    chk("aempty_r", 32'(aempty_r), 32'(n <= 2));
    chk("aempty_f", 32'(aempty_f), 32'(n <= 2));
    chk("afull_r",  32'(afull_r),  32'(n >= 6));
    chk("afull_f",  32'(afull_f),  32'(n >= 6));
    chk("ovf_r",    32'(ovf_r),    32'(exp_ovf));
    chk("ovf_f",    32'(ovf_f),    32'(exp_ovf));
    chk("unf_r",    32'(unf_r),    32'(exp_unf));
    chk("unf_f",    32'(unf_f),    32'(exp_unf));
  endtask

  // One clock of stimulus; called at posedge+1 and returns at the next posedge+1.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic rd_acc, wr_acc;
    logic [7:0] head;
    wr = w; wdata = d; rd = r;
    head = (model_q.size() == 0) ? 8'h00 : model_q[0];
    chk("fwft_data", 32'(rdata_f), 32'(head));
    rd_acc = r && (model_q.size() > 0);
    wr_acc = w && ((model_q.size() < 8) || rd_acc);
    if (rd_acc) exp_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    chk_state(w && !wr_acc, r && !rd_acc);
    if (rd_acc) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else begin
        last_rd = exp_q.pop_front();
        chk("reg_data", 32'(rdata_r), 32'(last_rd));
      end
    end else begin
      chk("reg_hold", 32'(rdata_r), 32'(last_rd));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_rd = 8'h00;
    chk_state(1'b0, 1'b0);
    chk("rst_data_r", 32'(rdata_r), 32'h0);
    chk("rst_data_f", 32'(rdata_f), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    @(posedge clk); #1;
    do_reset();
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h33, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);

    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    d = 8'h40;
    cycle(1'b1, d, 1'b0); d++;
    cycle(1'b1, d, 1'b0); d++;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, d, 1'b0); d++;
      cycle(1'b0, 8'h00, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, d, 1'b1); d++;
    end
    while (model_q.size() < 5) begin
      cycle(1'b1, d, 1'b0); d++;
    end
    chk("pre_rst_count", 32'(count_r), 32'd5);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
